// File: rtl/mips_exc_pkg.sv
// Shared definitions for the PC/exception stage: cause codes, vector FSM states,
// default handler-vector addresses and the exception priority encoder.
package mips_exc_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_OPCODE = 2'd1,
    CAUSE_OVF    = 2'd2,
    CAUSE_DIV0   = 2'd3
  } cause_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_LOAD = 2'd3
  } exc_state_t;

  localparam logic [31:0] DEF_VEC_OPCODE   = 32'd253;
  localparam logic [31:0] DEF_VEC_OVERFLOW = 32'd254;
  localparam logic [31:0] DEF_VEC_DIV0     = 32'd255;

  // Fixed priority: opcode beats overflow beats divide-by-zero.
  function automatic cause_t pick_cause(input logic opc, input logic ovf, input logic div0);
    if (opc) begin
      return CAUSE_OPCODE;
    end else if (ovf) begin
      return CAUSE_OVF;
    end else if (div0) begin
      return CAUSE_DIV0;
    end else begin
      return CAUSE_NONE;
    end
  endfunction

endpackage

// File: rtl/exc_vector_fsm.sv
// Exception sequencer: IDLE -> REQ -> WAIT -> LOAD. Issues the one-cycle vector
// read strobe, waits out the memory latency and flags the handler-PC load.
module exc_vector_fsm
  import mips_exc_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic idle,
  output logic load_pc,
  output logic mem_rd_req,
  output logic exc_busy,
  output logic exc_done
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  exc_state_t    state;
  logic [CW-1:0] cnt;

  assign idle    = (state == ST_IDLE);
  // The handler byte is sampled on the edge that leaves WAIT, so the new PC and
  // exc_done appear together in the LOAD cycle.
  assign load_pc = (state == ST_WAIT) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      mem_rd_req <= 1'b0;
      exc_busy   <= 1'b0;
      exc_done   <= 1'b0;
    end else begin
      mem_rd_req <= 1'b0;
      exc_done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_REQ;
            mem_rd_req <= 1'b1;
            exc_busy   <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_REQ: begin
          cnt   <= CW'(MEM_LAT - 1);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state    <= ST_LOAD;
            exc_done <= 1'b1;
            exc_busy <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_LOAD: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pc_exception_unit.sv
// PC register stage with EPC/CAUSE capture and handler-vector fetch.
// Optional macro PC_ALIGN_CHECK_EN suppresses misaligned PC writes and sets misalign_err.
module pc_exception_unit
  import mips_exc_pkg::*;
#(
  parameter logic [31:0] VEC_OPCODE   = DEF_VEC_OPCODE,
  parameter logic [31:0] VEC_OVERFLOW = DEF_VEC_OVERFLOW,
  parameter logic [31:0] VEC_DIV0     = DEF_VEC_DIV0,
  parameter int          MEM_LAT      = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic        zero,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [7:0]  mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic [31:0] mem_addr,
  output logic        mem_rd_req,
  output logic        exc_busy,
  output logic        exc_done,
  output logic        misalign_err
);

  logic        idle;
  logic        load_pc;
  logic        any_exc;
  logic        accept;
  logic        wr_en;
  logic        align_ok;
  cause_t      code;
  logic [31:0] vec;

  assign any_exc = exc_opcode | exc_overflow | exc_div0;
  assign accept  = idle & any_exc;
  assign code    = pick_cause(exc_opcode, exc_overflow, exc_div0);
  // An exception in the same cycle wins over any PC write.
  assign wr_en   = idle & ~any_exc & (pc_write | (pc_write_cond & zero));

`ifdef PC_ALIGN_CHECK_EN
  assign align_ok = (pc_next[1:0] == 2'b00);
`else
  assign align_ok = 1'b1;
`endif

  // Handler-vector address for the accepted cause.
  always_comb begin
    vec = 32'd0;
    case (code)
      CAUSE_OPCODE: vec = VEC_OPCODE;
      CAUSE_OVF:    vec = VEC_OVERFLOW;
      CAUSE_DIV0:   vec = VEC_DIV0;
      default:      vec = 32'd0;
    endcase
  end

  exc_vector_fsm #(
    .MEM_LAT(MEM_LAT)
  ) u_fsm (
    .clk       (clk),
    .reset     (reset),
    .start     (accept),
    .idle      (idle),
    .load_pc   (load_pc),
    .mem_rd_req(mem_rd_req),
    .exc_busy  (exc_busy),
    .exc_done  (exc_done)
  );

  // PC, EPC, CAUSE, vector address and alignment flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= 32'd0;
      epc          <= 32'd0;
      cause        <= 2'd0;
      mem_addr     <= 32'd0;
      misalign_err <= 1'b0;
    end else begin
      if (load_pc) begin
        pc <= {24'd0, mem_rdata};
      end else if (wr_en && align_ok) begin
        pc <= pc_next;
      end
      if (accept) begin
        epc      <= pc - 32'd4;
        cause    <= code;
        mem_addr <= vec;
      end
`ifdef PC_ALIGN_CHECK_EN
      if (wr_en && !align_ok) begin
        misalign_err <= 1'b1;
      end
`else
      misalign_err <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_pc_exception_unit.sv
// Self-checking bench for pc_exception_unit: table-driven PC writes plus
// exception sequences, with a latency-accurate vector-memory model.
module tb_pc_exception_unit;

  localparam int MEM_LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_next;
  logic        pc_write, pc_write_cond, zero;
  logic        exc_opcode, exc_overflow, exc_div0;
  logic [7:0]  mem_rdata;
  logic [31:0] pc, epc, mem_addr;
  logic [1:0]  cause;
  logic        mem_rd_req, exc_busy, exc_done, misalign_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  handler_byte = 8'h00;
  logic [MEM_LAT:1] req_pipe = '0;
  int rd_cnt = 0;
  int done_cnt = 0;

  typedef struct {
    logic [31:0] pc_next;
    logic        w;
    logic        c;
    logic        z;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vt[6];

  pc_exception_unit #(.MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset), .pc_next(pc_next), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .zero(zero), .exc_opcode(exc_opcode),
    .exc_overflow(exc_overflow), .exc_div0(exc_div0), .mem_rdata(mem_rdata),
    .pc(pc), .epc(epc), .cause(cause), .mem_addr(mem_addr), .mem_rd_req(mem_rd_req),
    .exc_busy(exc_busy), .exc_done(exc_done), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Memory returns valid data only in the cycle MEM_LAT after the strobe cycle.
  assign mem_rdata = req_pipe[MEM_LAT] ? handler_byte : 8'hEE;
  always @(posedge clk) begin
    req_pipe <= {req_pipe[MEM_LAT-1:1], mem_rd_req};
    rd_cnt   <= rd_cnt + (mem_rd_req ? 1 : 0);
    done_cnt <= done_cnt + (exc_done ? 1 : 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    pc_next = 32'd0; pc_write = 1'b0; pc_write_cond = 1'b0; zero = 1'b0;
    exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0;
  endtask

  // Waits for exc_done; lat counts cycles since the exception cycle.
  task automatic wait_done(input bit repulse, output int lat);
    lat = 1;
    while (exc_done !== 1'b1 && lat < 40) begin
      if (repulse && lat == 2) begin
        exc_div0 = 1'b1; exc_opcode = 1'b1; pc_write = 1'b1; pc_next = 32'h700;
      end else begin
        clear_inputs();
      end
      step();
      lat++;
    end
    clear_inputs();
    check("exc_done_seen", {31'd0, exc_done}, 32'd1);
  endtask

  initial begin
    int lat;
    int rd0, done0;
    vt[0] = '{32'h40,  1'b1, 1'b0, 1'b0, 32'h40};
    vt[1] = '{32'h80,  1'b0, 1'b1, 1'b0, 32'h40};
    vt[2] = '{32'h80,  1'b0, 1'b1, 1'b1, 32'h80};
    vt[3] = '{32'hC0,  1'b0, 1'b0, 1'b1, 32'h80};
    vt[4] = '{32'h100, 1'b1, 1'b1, 1'b0, 32'h100};
    vt[5] = '{32'h200, 1'b0, 1'b0, 1'b0, 32'h100};

    clear_inputs();
    reset = 1'b1;
    step(); step();
    check("rst_pc", pc, 32'd0);
    check("rst_epc", epc, 32'd0);
    check("rst_cause", {30'd0, cause}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rd_req", {31'd0, mem_rd_req}, 32'd0);
    check("rst_busy", {31'd0, exc_busy}, 32'd0);
    check("rst_done", {31'd0, exc_done}, 32'd0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
    reset = 1'b0;

    // Plain and conditional PC writes in IDLE.
    for (int i = 0; i < 6; i++) begin
      pc_next = vt[i].pc_next; pc_write = vt[i].w;
      pc_write_cond = vt[i].c; zero = vt[i].z;
      exp_q.push_back(vt[i].exp_pc);
      step();
      check($sformatf("vec%0d_pc", i), pc, exp_q.pop_front());
    end
    clear_inputs();

    // Overflow exception from pc=0x100.
    rd0 = rd_cnt; done0 = done_cnt;
    handler_byte = 8'h3C;
    exp_q.push_back(32'h3C);
    exc_overflow = 1'b1;
    step();
    clear_inputs();
    check("ovf_busy", {31'd0, exc_busy}, 32'd1);
    check("ovf_epc", epc, 32'hFC);
    check("ovf_cause", {30'd0, cause}, 32'd2);
    check("ovf_mem_addr", mem_addr, 32'd254);
    check("ovf_rd_req", {31'd0, mem_rd_req}, 32'd1);
    check("ovf_pc_hold", pc, 32'h100);
    wait_done(1'b0, lat);
    check("ovf_latency", lat, 2 + MEM_LAT);
    check("ovf_handler_pc", pc, exp_q.pop_front());
    check("ovf_busy_clr", {31'd0, exc_busy}, 32'd0);
    check("ovf_rd_pulses", rd_cnt - rd0, 32'd1);
    step();
    check("ovf_done_pulse", {31'd0, exc_done}, 32'd0);
    check("ovf_done_count", done_cnt - done0, 32'd1);

    // Simultaneous opcode + div0 + pc_write from pc=0.
    reset = 1'b1; step(); reset = 1'b0;
    handler_byte = 8'h20;
    exp_q.push_back(32'h20);
    exc_opcode = 1'b1; exc_div0 = 1'b1; pc_write = 1'b1; pc_next = 32'h500;
    step();
    clear_inputs();
    check("prio_cause", {30'd0, cause}, 32'd1);
    check("prio_epc", epc, 32'hFFFFFFFC);
    check("prio_mem_addr", mem_addr, 32'd253);
    check("prio_pc_not_written", pc, 32'd0);
    wait_done(1'b0, lat);
    check("prio_handler_pc", pc, exp_q.pop_front());
    step();

    // Div0 with further events while busy.
    rd0 = rd_cnt; done0 = done_cnt;
    handler_byte = 8'h30;
    exp_q.push_back(32'h30);
    exc_div0 = 1'b1;
    step();
    clear_inputs();
    wait_done(1'b1, lat);
    check("busy_latency", lat, 2 + MEM_LAT);
    check("busy_handler_pc", pc, exp_q.pop_front());
    check("busy_cause", {30'd0, cause}, 32'd3);
    check("busy_epc", epc, 32'h1C);
    check("busy_mem_addr", mem_addr, 32'd255);
    for (int i = 0; i < 6; i++) step();
    check("busy_done_count", done_cnt - done0, 32'd1);
    check("busy_rd_pulses", rd_cnt - rd0, 32'd1);
    check("busy_pc_after", pc, 32'h30);

    // Reset while waiting for memory aborts the sequence.
    done0 = done_cnt;
    handler_byte = 8'h55;
    exc_overflow = 1'b1;
    step();
    clear_inputs();
    step();
    check("abort_in_wait_busy", {31'd0, exc_busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_pc", pc, 32'd0);
    check("abort_busy", {31'd0, exc_busy}, 32'd0);
    check("abort_cause", {30'd0, cause}, 32'd0);
    for (int i = 0; i < 6; i++) step();
    check("abort_no_done", done_cnt - done0, 32'd0);
    check("abort_pc_after", pc, 32'd0);

    // Misaligned write, then an aligned one.
    pc_next = 32'h42; pc_write = 1'b1;
    step();
`ifdef PC_ALIGN_CHECK_EN
    check("align_pc_hold", pc, 32'd0);
    check("align_err_set", {31'd0, misalign_err}, 32'd1);
`else
    check("noalign_pc", pc, 32'h42);
    check("noalign_err", {31'd0, misalign_err}, 32'd0);
`endif
    pc_next = 32'h44;
    step();
    clear_inputs();
    step();
    check("align_next_pc", pc, 32'h44);
`ifdef PC_ALIGN_CHECK_EN
    check("align_err_sticky", {31'd0, misalign_err}, 32'd1);
`else
    check("noalign_err_after", {31'd0, misalign_err}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
